// File: rtl/cmsdk_apb4_eg_slave_arb_pkg.sv
// Shared types and constants for the two-requester APB4 example-slave arbiter.
package cmsdk_apb4_eg_slave_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  localparam int ID_W         = 1;
  localparam int ACCESS_BYTES = 4;
  localparam int DATA_W       = 8 * ACCESS_BYTES;

endpackage

// File: rtl/cmsdk_apb4_eg_slave_arb_if.sv
// Requester and register-interface bundle for cmsdk_apb4_eg_slave_arb.
// Lock inputs exist only when CMSDK_APB4_EG_ARB_LOCK_EN is defined.
interface cmsdk_apb4_eg_slave_arb_if #(
  parameter int ADDRWIDTH = 12
);
  import cmsdk_apb4_eg_slave_arb_pkg::*;

  logic                    req0, write0, ack0;
  logic [ADDRWIDTH-1:0]    addr0;
  logic [ACCESS_BYTES-1:0] strb0;
  logic [DATA_W-1:0]       wdata0, rdata0;

  logic                    req1, write1, ack1;
  logic [ADDRWIDTH-1:0]    addr1;
  logic [ACCESS_BYTES-1:0] strb1;
  logic [DATA_W-1:0]       wdata1, rdata1;

`ifdef CMSDK_APB4_EG_ARB_LOCK_EN
  logic                    lock0, lock1;
`endif

  logic [ADDRWIDTH-1:0]    addr;
  logic                    read_en, write_en, busy;
  logic [ACCESS_BYTES-1:0] byte_strobe;
  logic [DATA_W-1:0]       wdata, rdata;

  // Arbiter view: serves both requesters and drives the register block.
  modport slave (
    input  req0, write0, addr0, strb0, wdata0,
    input  req1, write1, addr1, strb1, wdata1,
`ifdef CMSDK_APB4_EG_ARB_LOCK_EN
    input  lock0, lock1,
`endif
    input  rdata,
    output ack0, rdata0, ack1, rdata1,
    output addr, read_en, write_en, byte_strobe, wdata, busy
  );

  modport master (
    output req0, write0, addr0, strb0, wdata0,
    output req1, write1, addr1, strb1, wdata1,
`ifdef CMSDK_APB4_EG_ARB_LOCK_EN
    output lock0, lock1,
`endif
    output rdata,
    input  ack0, rdata0, ack1, rdata1,
    input  addr, read_en, write_en, byte_strobe, wdata, busy
  );

endinterface

// File: rtl/cmsdk_apb4_eg_slave_arb_rr.sv
// Combinational two-way round-robin pick with optional hold of the last winner.
module cmsdk_apb4_eg_slave_arb_rr
  import cmsdk_apb4_eg_slave_arb_pkg::*;
(
  input  logic [1:0]      req,
  input  logic [ID_W-1:0] last_grant,
  input  logic            lock_hold,
  output logic            gnt_valid,
  output logic [ID_W-1:0] gnt_id
);

  always_comb begin
    gnt_valid = |req;
    gnt_id    = last_grant;
    if (req == 2'b11) begin
      gnt_id = lock_hold ? last_grant : ~last_grant;
    end else if (req[1]) begin
      gnt_id = 1'b1;
    end else begin
      gnt_id = 1'b0;
    end
  end

endmodule

// File: rtl/cmsdk_apb4_eg_slave_arb.sv
// Round-robin arbiter and one-access-at-a-time sequencer for the APB4 example slave.
// Define CMSDK_APB4_EG_ARB_LOCK_EN to add lock0/lock1 back-to-back grant holding.
module cmsdk_apb4_eg_slave_arb
  import cmsdk_apb4_eg_slave_arb_pkg::*;
#(
  parameter int ADDRWIDTH = 12
) (
  input  logic                      pclk,
  input  logic                      preset,
  cmsdk_apb4_eg_slave_arb_if.slave  bus
);

  state_t                  state_reg, state_next;
  logic [ID_W-1:0]         last_grant_reg, last_grant_next;
  logic [ID_W-1:0]         gnt_id_reg, gnt_id_next;
  logic                    load_payload, capture_rdata;

  logic                    pay_write_reg;
  logic [ADDRWIDTH-1:0]    pay_addr_reg;
  logic [ACCESS_BYTES-1:0] pay_strb_reg;
  logic [DATA_W-1:0]       pay_wdata_reg;
  logic [DATA_W-1:0]       rdata_reg [2];
  logic [1:0]              ack_vec;

  logic                    rr_valid;
  logic [ID_W-1:0]         rr_id;
  logic                    lock_hold;

  cmsdk_apb4_eg_slave_arb_rr u_rr (
    .req        ({bus.req1, bus.req0}),
    .last_grant (last_grant_reg),
    .lock_hold  (lock_hold),
    .gnt_valid  (rr_valid),
    .gnt_id     (rr_id)
  );

`ifdef CMSDK_APB4_EG_ARB_LOCK_EN
  logic lock_hold_reg;
  // Lock is sampled in DONE and only honoured in the IDLE cycle right after it.
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      lock_hold_reg <= 1'b0;
    end else if (state_reg == ST_DONE) begin
      lock_hold_reg <= (gnt_id_reg == 1'b1) ? bus.lock1 : bus.lock0;
    end else begin
      lock_hold_reg <= 1'b0;
    end
  end
  assign lock_hold = lock_hold_reg;
`else
  assign lock_hold = 1'b0;
`endif

  always_comb begin
    state_next      = state_reg;
    last_grant_next = last_grant_reg;
    gnt_id_next     = gnt_id_reg;
    load_payload    = 1'b0;
    capture_rdata   = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (rr_valid) begin
          gnt_id_next  = rr_id;
          load_payload = 1'b1;
          state_next   = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        capture_rdata   = ~pay_write_reg;
        last_grant_next = gnt_id_reg;
        state_next      = ST_DONE;
      end
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      state_reg      <= ST_IDLE;
      last_grant_reg <= 1'b1;
      gnt_id_reg     <= '0;
      pay_write_reg  <= 1'b0;
      pay_addr_reg   <= '0;
      pay_strb_reg   <= '0;
      pay_wdata_reg  <= '0;
    end else begin
      state_reg      <= state_next;
      last_grant_reg <= last_grant_next;
      gnt_id_reg     <= gnt_id_next;
      if (load_payload) begin
        pay_write_reg <= (rr_id == 1'b1) ? bus.write1 : bus.write0;
        pay_addr_reg  <= (rr_id == 1'b1) ? bus.addr1  : bus.addr0;
        pay_strb_reg  <= (rr_id == 1'b1) ? bus.strb1  : bus.strb0;
        pay_wdata_reg <= (rr_id == 1'b1) ? bus.wdata1 : bus.wdata0;
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_req
      always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
          rdata_reg[gi] <= '0;
        end else if (capture_rdata && (gnt_id_reg == ID_W'(gi))) begin
          rdata_reg[gi] <= bus.rdata;
        end
      end
      assign ack_vec[gi] = (state_reg == ST_DONE) && (gnt_id_reg == ID_W'(gi));
    end
  endgenerate

  assign bus.ack0   = ack_vec[0];
  assign bus.ack1   = ack_vec[1];
  assign bus.rdata0 = rdata_reg[0];
  assign bus.rdata1 = rdata_reg[1];

  // addr simply holds the last granted address; strobes and data are gated to ACCESS.
  assign bus.addr        = pay_addr_reg;
  assign bus.read_en     = (state_reg == ST_ACCESS) && !pay_write_reg;
  assign bus.write_en    = (state_reg == ST_ACCESS) &&  pay_write_reg;
  assign bus.byte_strobe = bus.write_en ? pay_strb_reg  : '0;
  assign bus.wdata       = bus.write_en ? pay_wdata_reg : '0;
  assign bus.busy        = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_cmsdk_apb4_eg_slave_arb.sv
// Directed bench for cmsdk_apb4_eg_slave_arb with a behavioural model of the example slave.
module tb_cmsdk_apb4_eg_slave_arb;

  typedef struct {
    bit          id;
    bit          wr;
    logic [11:0] addr;
    logic [3:0]  strb;
    logic [31:0] wd;
    logic [31:0] exp;
  } vec_t;

  logic pclk = 1'b0;
  logic preset;
  always #5 pclk = ~pclk;

  cmsdk_apb4_eg_slave_arb_if #(.ADDRWIDTH(12)) bus ();

  cmsdk_apb4_eg_slave_arb #(.ADDRWIDTH(12)) dut (
    .pclk   (pclk),
    .preset (preset),
    .bus    (bus)
  );

  // Example-slave model: four data words at 0x000-0x00C plus ID registers.
  logic [31:0] data_mem [4];
  always @(posedge pclk) begin
    if (bus.write_en && bus.addr[11:4] == 8'h00) begin
      for (int b = 0; b < 4; b++)
        if (bus.byte_strobe[b]) data_mem[bus.addr[3:2]][b*8 +: 8] <= bus.wdata[b*8 +: 8];
    end
  end
  always_comb begin
    bus.rdata = 32'h0;
    if (bus.read_en) begin
      if (bus.addr[11:4] == 8'h00) bus.rdata = data_mem[bus.addr[3:2]];
      else begin
        case (bus.addr[11:2])
          10'h3F4: bus.rdata = 32'h04;
          10'h3F8: bus.rdata = 32'h19;
          10'h3F9: bus.rdata = 32'hB8;
          10'h3FA: bus.rdata = 32'h1B;
          10'h3FC: bus.rdata = 32'h0D;
          10'h3FD: bus.rdata = 32'hF0;
          10'h3FE: bus.rdata = 32'h05;
          10'h3FF: bus.rdata = 32'hB1;
          default: bus.rdata = 32'h0;
        endcase
      end
    end
  end

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] exp_rd [2];

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endfunction

  task automatic set_req(input bit id, input bit r, input bit wr, input logic [11:0] a,
                         input logic [3:0] s, input logic [31:0] d);
    if (id == 1'b0) begin
      bus.req0 = r; bus.write0 = wr; bus.addr0 = a; bus.strb0 = s; bus.wdata0 = d;
    end else begin
      bus.req1 = r; bus.write1 = wr; bus.addr1 = a; bus.strb1 = s; bus.wdata1 = d;
    end
  endtask

  // Called just after a negedge with the FSM in IDLE.
  task automatic xact(input vec_t v);
    logic [31:0] got_rd;
    set_req(v.id, 1'b1, v.wr, v.addr, v.strb, v.wd);
    @(negedge pclk);
    chk("acc_busy", 32'(bus.busy), 32'd1);
    chk("acc_addr", 32'(bus.addr), 32'(v.addr));
    chk("acc_we",   32'(bus.write_en), 32'(v.wr));
    chk("acc_re",   32'(bus.read_en), 32'(!v.wr));
    chk("acc_strb", 32'(bus.byte_strobe), v.wr ? 32'(v.strb) : 32'd0);
    chk("acc_wdata", bus.wdata, v.wr ? v.wd : 32'd0);
    chk("acc_noack", 32'({bus.ack1, bus.ack0}), 32'd0);
    @(negedge pclk);
    if (!v.wr) exp_rd[v.id] = v.exp;
    got_rd = v.id ? bus.rdata1 : bus.rdata0;
    chk("done_ack", 32'({bus.ack1, bus.ack0}), v.id ? 32'd2 : 32'd1);
    chk("done_en", 32'({bus.read_en, bus.write_en}), 32'd0);
    chk("done_rdata", got_rd, exp_rd[v.id]);
    set_req(v.id, 1'b0, 1'b0, 12'h0, 4'h0, 32'h0);
    @(negedge pclk);
    chk("idle_ack", 32'({bus.ack1, bus.ack0}), 32'd0);
    chk("idle_busy", 32'(bus.busy), 32'd0);
    $display("xact req%0d %s addr=%h strb=%h wdata=%h rdata=%h", v.id, v.wr ? "WR" : "RD",
             v.addr, v.strb, v.wd, got_rd);
  endtask

  task automatic do_reset();
    preset = 1'b1;
    @(negedge pclk);
    @(negedge pclk);
    preset = 1'b0;
    exp_rd[0] = 32'h0;
    exp_rd[1] = 32'h0;
  endtask

  vec_t vecs [9];
  int   seq [$];
  logic [1:0] ackv, prev;

  initial begin
    for (int i = 0; i < 4; i++) data_mem[i] = 32'h0;
    set_req(1'b0, 1'b0, 1'b0, 12'h0, 4'h0, 32'h0);
    set_req(1'b1, 1'b0, 1'b0, 12'h0, 4'h0, 32'h0);
`ifdef CMSDK_APB4_EG_ARB_LOCK_EN
    bus.lock0 = 1'b0;
    bus.lock1 = 1'b0;
`endif
    preset = 1'b1;
    @(negedge pclk);
    chk("rst_busy",  32'(bus.busy), 32'd0);
    chk("rst_ack",   32'({bus.ack1, bus.ack0}), 32'd0);
    chk("rst_rd0",   bus.rdata0, 32'd0);
    chk("rst_rd1",   bus.rdata1, 32'd0);
    chk("rst_addr",  32'(bus.addr), 32'd0);
    chk("rst_en",    32'({bus.read_en, bus.write_en}), 32'd0);
    chk("rst_strb",  32'(bus.byte_strobe), 32'd0);
    chk("rst_wdata", bus.wdata, 32'd0);
    do_reset();

    vecs[0] = '{1'b0, 1'b1, 12'h004, 4'hF, 32'hDEADBEEF, 32'h0};
    vecs[1] = '{1'b0, 1'b0, 12'h004, 4'h0, 32'h0,        32'hDEADBEEF};
    vecs[2] = '{1'b1, 1'b1, 12'h008, 4'hF, 32'hAABBCCDD, 32'h0};
    vecs[3] = '{1'b1, 1'b1, 12'h008, 4'h5, 32'h11223344, 32'h0};
    vecs[4] = '{1'b0, 1'b0, 12'h008, 4'h0, 32'h0,        32'hAA22CC44};
    vecs[5] = '{1'b1, 1'b0, 12'hFE0, 4'h0, 32'h0,        32'h00000019};
    vecs[6] = '{1'b1, 1'b0, 12'h100, 4'h0, 32'h0,        32'h00000000};
    vecs[7] = '{1'b0, 1'b1, 12'h00C, 4'h0, 32'h12345678, 32'h0};
    vecs[8] = '{1'b1, 1'b0, 12'h00C, 4'h0, 32'h0,        32'h00000000};
    for (int i = 0; i < 9; i++) xact(vecs[i]);

    // Both requesters held from reset: expect alternating grants starting with 0.
    do_reset();
    set_req(1'b0, 1'b1, 1'b0, 12'h004, 4'h0, 32'h0);
    set_req(1'b1, 1'b1, 1'b0, 12'h008, 4'h0, 32'h0);
    prev = 2'b00;
    for (int k = 1; k <= 12; k++) begin
      @(negedge pclk);
      ackv = {bus.ack1, bus.ack0};
      chk("rr_excl", 32'(ackv == 2'b11), 32'd0);
      chk("rr_single", 32'((ackv & prev) != 2'b00), 32'd0);
      if (ackv[0]) begin seq.push_back(0); chk("rr_rd0", bus.rdata0, 32'hDEADBEEF); end
      if (ackv[1]) begin seq.push_back(1); chk("rr_rd1", bus.rdata1, 32'hAA22CC44); end
      prev = ackv;
    end
    set_req(1'b0, 1'b0, 1'b0, 12'h0, 4'h0, 32'h0);
    set_req(1'b1, 1'b0, 1'b0, 12'h0, 4'h0, 32'h0);
    chk("rr_count", 32'(seq.size()), 32'd4);
    for (int i = 0; i < seq.size(); i++) chk("rr_order", 32'(seq[i]), 32'(i % 2));
    $display("xact round-robin grants observed=%0d", seq.size());
    @(negedge pclk);

    // Reset pulsed during ACCESS: no ack, outputs cleared, then normal service.
    set_req(1'b0, 1'b1, 1'b0, 12'h004, 4'h0, 32'h0);
    @(negedge pclk);
    chk("rsta_busy_pre", 32'(bus.busy), 32'd1);
    preset = 1'b1;
    set_req(1'b0, 1'b0, 1'b0, 12'h0, 4'h0, 32'h0);
    #1;
    chk("rsta_busy", 32'(bus.busy), 32'd0);
    chk("rsta_en", 32'({bus.read_en, bus.write_en}), 32'd0);
    chk("rsta_addr", 32'(bus.addr), 32'd0);
    chk("rsta_rd0", bus.rdata0, 32'd0);
    @(negedge pclk);
    preset = 1'b0;
    exp_rd[0] = 32'h0;
    exp_rd[1] = 32'h0;
    for (int k = 0; k < 3; k++) begin
      @(negedge pclk);
      chk("rsta_noack", 32'({bus.ack1, bus.ack0}), 32'd0);
    end
    $display("xact reset-during-access checked");
    xact('{1'b1, 1'b0, 12'h004, 4'h0, 32'h0, 32'hDEADBEEF});

`ifdef CMSDK_APB4_EG_ARB_LOCK_EN
    // lock0 holds the grant for one extra access, then round-robin resumes.
    do_reset();
    seq.delete();
    bus.lock0 = 1'b1;
    set_req(1'b0, 1'b1, 1'b0, 12'h004, 4'h0, 32'h0);
    set_req(1'b1, 1'b1, 1'b0, 12'h008, 4'h0, 32'h0);
    for (int k = 1; k <= 9; k++) begin
      @(negedge pclk);
      if (k == 3) bus.lock0 = 1'b0;
      if (bus.ack0) seq.push_back(0);
      if (bus.ack1) seq.push_back(1);
    end
    set_req(1'b0, 1'b0, 1'b0, 12'h0, 4'h0, 32'h0);
    set_req(1'b1, 1'b0, 1'b0, 12'h0, 4'h0, 32'h0);
    chk("lock_count", 32'(seq.size()), 32'd3);
    if (seq.size() == 3) begin
      chk("lock_g0", 32'(seq[0]), 32'd0);
      chk("lock_g1", 32'(seq[1]), 32'd0);
      chk("lock_g2", 32'(seq[2]), 32'd1);
    end
    $display("xact lock sequence grants observed=%0d", seq.size());
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
